// File: rtl/fb_frame_writer.sv
// Ping-pong frame buffer writer: streams pixels into one bank while the
// display reads the other, swapping banks only at the display frame origin.
module fb_frame_writer #(
  parameter int IMG_W      = 200,
  parameter int IMG_H      = 200,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [10:0]           h_cnt,
  input  logic [10:0]           v_cnt,
  input  logic                  s_valid,
  input  logic                  s_sof,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  disp_bank,
  output logic                  frame_done,
  output logic                  sync_err,
  output logic [7:0]            frame_cnt
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(IMG_W * IMG_H - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pix_addr;

  logic                  w_accept;
  logic                  w_origin;
  logic                  w_last;
  logic                  w_resync;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign s_ready  = (r_state == FILL);
  assign w_accept = s_valid && s_ready;
  assign w_origin = (h_cnt == '0) && (v_cnt == '0);

  // An s_sof beat always lands at address 0; the last-pixel test uses
  // that resulting address so a 1-pixel image still completes.
  assign w_addr   = s_sof ? '0 : r_pix_addr;
  assign w_last   = (w_addr == LAST_ADDR);
  assign w_resync = s_sof && (r_pix_addr != '0);

  // wr_bank only flips in FULL, where no write can be in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FILL;
      r_pix_addr <= '0;
      wr_en      <= 1'b0;
      wr_bank    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      disp_bank  <= 1'b1;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      unique case (r_state)
        FILL: begin
          if (w_accept) begin
            wr_en    <= 1'b1;
            wr_addr  <= w_addr;
            wr_data  <= s_data;
            sync_err <= w_resync;
            if (w_last) begin
              r_pix_addr <= '0;
              r_state    <= FULL;
              frame_done <= 1'b1;
            end else begin
              r_pix_addr <= w_addr + 1'b1;
            end
          end
        end
        FULL: begin
          if (w_origin) begin
            disp_bank <= wr_bank;
            wr_bank   <= ~wr_bank;
            frame_cnt <= frame_cnt + 8'd1;
            r_state   <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/fb_frame_writer.md
# fb_frame_writer

Write-side companion to the frame-cycling VGA display: accepts a stream of 12-bit RGB pixels over a valid/ready handshake and writes them into a two-bank (ping-pong) frame buffer RAM. When a bank is completely filled, the block waits for the display's frame origin (h_cnt==0, v_cnt==0) and then swaps banks, so the display always reads a complete, stable frame. It drives the RAM write port and tells the display which bank to read.

## Interface
- IMG_W, 200, pixels per line of the stored image
- IMG_H, 200, lines per stored image
- ADDR_WIDTH, 16, per-bank address width; IMG_W*IMG_H must be ≤ 2**ADDR_WIDTH
- DATA_WIDTH, 12, pixel width ({r[3:0], g[3:0], b[3:0]})

- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- h_cnt  in  11  display horizontal counter
- v_cnt  in  11  display vertical counter
- s_valid  in  1  source pixel valid
- s_sof  in  1  start-of-frame marker, qualified by s_valid
- s_data  in  DATA_WIDTH  source pixel
- s_ready  out  1  block accepts a pixel this cycle
- wr_en  out  1  RAM write strobe
- wr_bank  out  1  bank being written (RAM address MSB)
- wr_addr  out  ADDR_WIDTH  RAM address within the bank
- wr_data  out  DATA_WIDTH  RAM write data
- disp_bank  out  1  bank the display reads
- frame_done  out  1  one-cycle pulse: bank filled
- sync_err  out  1  one-cycle pulse: s_sof seen mid-frame
- frame_cnt  out  8  count of completed bank swaps

## Operation
- Beat accepted when s_valid && s_ready. s_ready = (state == FILL), combinational from state only.
- States: FILL, FULL.
  - FILL: each accepted beat writes s_data at pix_addr in the current write bank; pix_addr increments. When the beat at pix_addr == IMG_W*IMG_H-1 is accepted: pix_addr <= 0, state <= FULL, frame_done pulses.
  - FULL: no beats accepted. On any cycle with h_cnt==0 && v_cnt==0: disp_bank <= wr_bank, wr_bank <= ~wr_bank, frame_cnt <= frame_cnt+1 (wraps 255→0), state <= FILL.
- Resync: an accepted beat with s_sof=1 is always written to address 0 and pix_addr <= 1. If pix_addr != 0 at that moment, sync_err pulses. An s_sof beat when pix_addr==0 is normal. The last-pixel rule applies to the resulting address, so IMG_W*IMG_H==1 still goes to FULL.
- An accepted beat with s_sof=0 at pix_addr==0 is accepted as the first pixel, with no error.
- Pixel addressing is linear: addr = y*IMG_W + x. This matches the display read order.
- Reset values: state FILL, pix_addr 0, wr_bank 0, disp_bank 1, frame_cnt 0, and wr_en, wr_addr, wr_data, frame_done and sync_err all 0. s_ready is 1 one cycle after reset release. Reset mid-frame discards the partial frame.

## Timing
- Write latency is 1 cycle. wr_en/wr_bank/wr_addr/wr_data are registered: they are valid the cycle after acceptance, with wr_en high for exactly one cycle per accepted beat.
- frame_done and sync_err are registered: they pulse the cycle after the triggering beat.
- Swap: if the origin condition is present in a cycle while in FULL, the new disp_bank/wr_bank and s_ready=1 appear the next cycle. The first pixel of the next frame can be accepted in that cycle.
- If the last pixel is accepted in the same cycle as the origin condition, there is no swap (state was FILL). The block waits for the next origin.
- wr_bank as seen on the RAM port is the bank captured with the beat. A swap never alters an in-flight registered write.
- Because the origin condition holds for only one clk per display frame, at most one swap occurs per display frame.
- Back-to-back acceptance is supported: one pixel per cycle in FILL.

## Test plan
- IMG_W=4, IMG_H=2. Reset, then stream 8 beats with s_valid held high and s_sof on the first -> wr_addr 0..7 in bank 0 on consecutive cycles; frame_done pulses once, one cycle after the 8th beat; s_ready goes low.
- While in FULL, hold s_valid=1, then raise the origin condition -> no writes before the origin; the next cycle has disp_bank=0, wr_bank=1, frame_cnt=1, s_ready=1.
- Fill bank 1, then trigger the origin -> disp_bank=1, wr_bank=0, frame_cnt=2; bank 0 is written again from address 0.
- After 3 beats, send an s_sof beat -> it is written to address 0, sync_err pulses once, and the following beat goes to address 1.
- The 8th beat coincides with h_cnt=0 and v_cnt=0 -> no swap; the swap happens only at the next origin pulse.
- Assert rst_n low mid-frame (after 5 beats) -> all outputs take their reset values immediately; after release the stream restarts at bank 0, address 0, with frame_cnt=0 and disp_bank=1.
